aes128_encr_round_ctrl: RTL and testbench
=========================================

// Module: aes128_encr_round_ctrl
// PURPOSE
//   Iterative AES-128 encryption sequencer. Accepts one 128-bit plaintext block per handshake
//   and performs the initial AddRoundKey itself. Drives an external single-round datapath
//   (SubBytes/ShiftRows/MixColumns/AddRoundKey) for rounds 1..10 and fetches round keys by index.
//   Returns the ciphertext on a valid/ready output. Sits between the host stream interface and
//   the round datapath + key-schedule storage.
// PARAMETERS
//   NUM_ROUNDS  10  rounds after initial AddRoundKey; fixed 10 for AES-128; key_idx_o width 4
//   RND_LAT     1   datapath latency: cycles from rnd_text_o/rnd_key_o stable to rnd_text_i valid; >=1
// PORTS
//   clk         in   1    system clock, all logic on rising edge
//   rst_n       in   1    synchronous reset, active low
//   in_valid    in   1    plaintext valid
//   in_ready    out  1    controller can accept plaintext
//   in_data     in   128  plaintext block
//   out_valid   out  1    ciphertext valid
//   out_ready   in   1    consumer accepts ciphertext
//   out_data    out  128  ciphertext block
//   flush_i     in   1    abandon current block, return to IDLE
//   key_idx_o   out  4    round-key index to key store (0..10)
//   key_i       in   128  round key for key_idx_o, same-cycle (combinational) lookup
//   rnd_text_o  out  128  state fed to round datapath
//   rnd_key_o   out  128  round key fed to round datapath (= key_i)
//   rnd_last_o  out  1    final round: datapath bypasses MixColumns
//   rnd_text_i  in   128  round datapath result
// BEHAVIOUR
//   - Reset (rst_n=0 at edge): state=IDLE, round=0, lat_cnt=0, state_q=0, out_valid=0, out_data=0.
//     in_ready=0 while rst_n=0.
//   - FSM IDLE -> ROUND -> DONE -> IDLE.
//   - IDLE: in_ready=1, key_idx_o=0. On in_valid&in_ready: state_q<=in_data^key_i, round<=1,
//     lat_cnt<=0, go ROUND.
//   - ROUND: rnd_text_o=state_q, key_idx_o=round, rnd_key_o=key_i, rnd_last_o=(round==NUM_ROUNDS).
//     All are held stable for RND_LAT cycles; lat_cnt counts 0..RND_LAT-1.
//     When lat_cnt==RND_LAT-1: state_q<=rnd_text_i, lat_cnt<=0.
//       If round==NUM_ROUNDS: go DONE, out_data<=rnd_text_i, out_valid<=1. Else round<=round+1.
//   - DONE: out_valid/out_data hold until out_valid&out_ready; then out_valid<=0, go IDLE.
//     in_ready stays 0 in DONE: no same-cycle accept.
//   - Latency: accept at cycle 0 -> out_valid at cycle NUM_ROUNDS*RND_LAT+1 (11 for RND_LAT=1).
//     Throughput is 1 block per NUM_ROUNDS*RND_LAT+2 cycles with out_ready=1.
//   - rnd_text_o/rnd_key_o outside ROUND: rnd_text_o=state_q, rnd_last_o=0, key_idx_o=0.
//   - flush_i=1 (any state) at edge: go IDLE, out_valid<=0, round<=0; data regs unchanged.
//     flush_i has priority over in_valid and over out_ready completion.
//   - round never exceeds NUM_ROUNDS; key_idx_o never exceeds 10.
//   - in_data is sampled only on the accept edge; changes elsewhere are ignored.
//   - Reset mid-block behaves as flush, plus the register clears listed above.
// CONFIGURATION
//   AES_ENCR_CTRL_PERF_EN defined: adds port blk_cnt_o out 32.
//     Counts completed output handshakes; saturates at 32'hFFFF_FFFF; reset to 0; unaffected by flush_i.
//   Undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//   Shared package aes_pkg:
//     - AES_NR=10, AES_BLK_W=128, AES_KIDX_W=4
//     - typedef aes_blk_t (logic [127:0])
//     - enum aes_ctrl_st_e {IDLE, ROUND, DONE}
//   Single module. No sub-module; FSM and counters are small enough to stay flat.
// TESTING
//   1. FIPS-197 C.1: key 000102..0f, pt 00112233445566778899aabbccddeeff, RND_LAT=1
//      -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid at cycle 11.
//   2. Same vector, RND_LAT=3 -> same ciphertext, out_valid at cycle 31;
//      rnd_text_o/key_idx_o stable for 3 cycles per round; key_idx_o sequence 0,1..10.
//   3. Backpressure: out_ready=0 for 20 cycles -> out_valid/out_data held, in_ready=0 throughout.
//      out_ready=1 -> in_ready=1 next cycle.
//   4. flush_i pulse in round 5 -> IDLE next cycle, out_valid never asserts.
//      Next block (pt 0, key 0) -> 66e94bd4ef8a2c3b884cfa59ca342b2e.
//   5. rst_n low for 1 cycle in round 7 -> out_valid=0, out_data=0, in_ready=1 after release.
//   6. AES_ENCR_CTRL_PERF_EN: 4 back-to-back blocks -> blk_cnt_o=4; a flushed block does not count.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: block/key-index widths, the round count and the
// state encoding of the encryption round controller.
package aes_pkg;

    localparam int AES_NR     = 10;
    localparam int AES_BLK_W  = 128;
    localparam int AES_KIDX_W = 4;

    typedef logic [AES_BLK_W-1:0] aes_blk_t;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } aes_ctrl_st_e;

endpackage

// File: rtl/aes128_encr_round_ctrl.sv
// Iterative AES-128 encryption sequencer driving an external single-round datapath.
// Optional block counter port blk_cnt_o is enabled by defining AES_ENCR_CTRL_PERF_EN.
module aes128_encr_round_ctrl
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = AES_NR,
    parameter int RND_LAT    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [AES_BLK_W-1:0]  in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [AES_BLK_W-1:0]  out_data,
    input  logic                  flush_i,
    output logic [AES_KIDX_W-1:0] key_idx_o,
    input  logic [AES_BLK_W-1:0]  key_i,
    output logic [AES_BLK_W-1:0]  rnd_text_o,
    output logic [AES_BLK_W-1:0]  rnd_key_o,
    output logic                  rnd_last_o,
    input  logic [AES_BLK_W-1:0]  rnd_text_i
`ifdef AES_ENCR_CTRL_PERF_EN
    ,
    output logic [31:0]           blk_cnt_o
`endif
);

    localparam int                    LAT_W    = (RND_LAT > 1) ? $clog2(RND_LAT) : 1;
    localparam logic [AES_KIDX_W-1:0] LAST_RND = AES_KIDX_W'(NUM_ROUNDS);
    localparam logic [LAT_W-1:0]      LAT_LAST = LAT_W'(RND_LAT - 1);

    aes_ctrl_st_e          fsm_q;
    aes_ctrl_st_e          fsm_d;
    logic [AES_KIDX_W-1:0] round;
    logic [LAT_W-1:0]      lat_cnt;
    logic [AES_BLK_W-1:0]  state_q;
    logic                  accept;
    logic                  lat_done;
    logic                  last_rnd;
    logic                  out_fire;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q <= IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // Datapath inputs stay static for the whole round so the external round
    // logic sees stable operands for all RND_LAT cycles.
    always_comb begin
        fsm_d      = fsm_q;
        in_ready   = 1'b0;
        key_idx_o  = '0;
        rnd_last_o = 1'b0;
        rnd_text_o = state_q;
        rnd_key_o  = key_i;
        accept     = 1'b0;
        lat_done   = 1'b0;
        out_fire   = 1'b0;
        last_rnd   = (round == LAST_RND);
        case (fsm_q)
            IDLE: begin
                in_ready = rst_n;
                accept   = in_valid && in_ready;
                if (accept) begin
                    fsm_d = ROUND;
                end
            end
            ROUND: begin
                key_idx_o  = round;
                rnd_last_o = last_rnd;
                lat_done   = (lat_cnt == LAT_LAST);
                if (lat_done && last_rnd) begin
                    fsm_d = DONE;
                end
            end
            DONE: begin
                out_fire = out_valid && out_ready && !flush_i;
                if (out_fire) begin
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
        if (flush_i) begin
            fsm_d = IDLE;
        end
    end

    // Flush abandons the block but keeps the data registers untouched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            round     <= '0;
            lat_cnt   <= '0;
            state_q   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (flush_i) begin
            round     <= '0;
            lat_cnt   <= '0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                state_q <= in_data ^ key_i;
                round   <= AES_KIDX_W'(1);
                lat_cnt <= '0;
            end
            if (fsm_q == ROUND) begin
                if (lat_done) begin
                    state_q <= rnd_text_i;
                    lat_cnt <= '0;
                    if (last_rnd) begin
                        out_data  <= rnd_text_i;
                        out_valid <= 1'b1;
                    end else begin
                        round <= round + 1'b1;
                    end
                end else begin
                    lat_cnt <= lat_cnt + 1'b1;
                end
            end
            if (out_fire) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef AES_ENCR_CTRL_PERF_EN
    logic [31:0] blk_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blk_cnt <= '0;
        end else if (out_fire && (blk_cnt != 32'hFFFF_FFFF)) begin
            blk_cnt <= blk_cnt + 32'd1;
        end
    end

    assign blk_cnt_o = blk_cnt;
`endif

endmodule

// File: tb/tb_aes128_encr_round_ctrl.sv
// Directed bench: two controllers (RND_LAT 1 and 3) each driving a behavioural
// AES round datapath and key store, checked against FIPS-197 ciphertexts.
module tb_aes128_encr_round_ctrl;
    import aes_pkg::*;

    localparam int       NLANE   = 2;
    localparam aes_blk_t C1_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam aes_blk_t C1_PT   = 128'h00112233445566778899aabbccddeeff;
    localparam aes_blk_t C1_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam aes_blk_t ZERO_CT = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid   [NLANE];
    logic       in_ready   [NLANE];
    aes_blk_t   in_data    [NLANE];
    logic       out_valid  [NLANE];
    logic       out_ready  [NLANE];
    aes_blk_t   out_data   [NLANE];
    logic       flush      [NLANE];
    logic [3:0] key_idx    [NLANE];
    aes_blk_t   key_in     [NLANE];
    aes_blk_t   rnd_text   [NLANE];
    aes_blk_t   rnd_key    [NLANE];
    logic       rnd_last   [NLANE];
    aes_blk_t   rnd_result [NLANE];
`ifdef AES_ENCR_CTRL_PERF_EN
    logic [31:0] blk_cnt   [NLANE];
`endif

    logic [7:0] sbox_tab [256];
    aes_blk_t   rk_tab   [11];
    int         tests;
    int         fails;

    always #5 clk = ~clk;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t = {b, b} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sboxCalc(input logic [7:0] a);
        logic [7:0] inv = 8'h00;
        if (a != 8'h00) begin
            inv = 8'h01;
            for (int i = 0; i < 254; i++) inv = gmul(inv, a);
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    // One full AES round on a big-endian state; byte i sits at bits [127-8i -: 8].
    function automatic aes_blk_t aes_round(input aes_blk_t st, input aes_blk_t rk, input logic last);
        logic [7:0] b [16];
        logic [7:0] t [16];
        logic [7:0] a0, a1, a2, a3;
        aes_blk_t   res;
        for (int i = 0; i < 16; i++) b[i] = sbox_tab[st[127-8*i -: 8]];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[4*c+r] = b[4*((c+r)%4)+r];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = gmul(a0, 8'd2) ^ gmul(a1, 8'd3) ^ a2 ^ a3;
                t[4*c+1] = a0 ^ gmul(a1, 8'd2) ^ gmul(a2, 8'd3) ^ a3;
                t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'd2) ^ gmul(a3, 8'd3);
                t[4*c+3] = gmul(a0, 8'd3) ^ a1 ^ a2 ^ gmul(a3, 8'd2);
            end
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = t[i] ^ rk[127-8*i -: 8];
        return res;
    endfunction

    for (genvar g = 0; g < NLANE; g++) begin : g_lane
        localparam int LAT = (g == 0) ? 1 : 3;
        aes_blk_t rnd_res;

        aes128_encr_round_ctrl #(
            .NUM_ROUNDS (AES_NR),
            .RND_LAT    (LAT)
        ) dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .in_valid   (in_valid[g]),
            .in_ready   (in_ready[g]),
            .in_data    (in_data[g]),
            .out_valid  (out_valid[g]),
            .out_ready  (out_ready[g]),
            .out_data   (out_data[g]),
            .flush_i    (flush[g]),
            .key_idx_o  (key_idx[g]),
            .key_i      (key_in[g]),
            .rnd_text_o (rnd_text[g]),
            .rnd_key_o  (rnd_key[g]),
            .rnd_last_o (rnd_last[g]),
            .rnd_text_i (rnd_result[g])
`ifdef AES_ENCR_CTRL_PERF_EN
            ,
            .blk_cnt_o  (blk_cnt[g])
`endif
        );

        assign key_in[g] = (key_idx[g] <= 4'd10) ? rk_tab[key_idx[g]] : '0;
        assign rnd_res   = aes_round(rnd_text[g], rnd_key[g], rnd_last[g]);

        // Result only becomes correct after LAT-1 register stages.
        if (LAT == 1) begin : g_comb
            assign rnd_result[g] = rnd_res;
        end else begin : g_pipe
            aes_blk_t pipe [LAT-1];
            always @(posedge clk) begin
                pipe[0] <= rnd_res;
                for (int s = 1; s < LAT - 1; s++) pipe[s] <= pipe[s-1];
            end
            assign rnd_result[g] = pipe[LAT-2];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic setKey(input aes_blk_t key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]} ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic applyStimulus(input int g, input aes_blk_t pt);
        in_data[g]  = pt;
        in_valid[g] = 1'b1;
        step();
        in_valid[g] = 1'b0;
        in_data[g]  = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    task automatic runBlock(input int g, input int lat, input aes_blk_t pt, input aes_blk_t exp_ct);
        int       j    = 0;
        int       rnd;
        aes_blk_t held = '0;
        checkOutput("idle_in_ready", in_ready[g], 1);
        checkOutput("idle_key_idx", key_idx[g], 0);
        applyStimulus(g, pt);
        checkOutput("initial_addkey", rnd_text[g], pt ^ rk_tab[0]);
        while (!out_valid[g] && j < 10 * lat + 5) begin
            rnd = j / lat + 1;
            checkOutput("key_idx_seq", key_idx[g], rnd);
            checkOutput("rnd_last", rnd_last[g], rnd == 10);
            if (j % lat == 0) held = rnd_text[g];
            else checkOutput("rnd_text_hold", rnd_text[g], held);
            step();
            j++;
        end
        checkOutput("out_valid_cycle", j + 1, 10 * lat + 1);
        checkOutput("ciphertext", out_data[g], exp_ct);
        checkOutput("in_ready_in_done", in_ready[g], 0);
    endtask

    task automatic finishBlock(input int g);
        out_ready[g] = 1'b1;
        step();
        out_ready[g] = 1'b0;
        checkOutput("out_valid_cleared", out_valid[g], 0);
        checkOutput("in_ready_after_out", in_ready[g], 1);
    endtask

    initial begin
        #500_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit seen;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        for (int g = 0; g < NLANE; g++) begin
            in_valid[g]  = 1'b0;
            in_data[g]   = '0;
            out_ready[g] = 1'b0;
            flush[g]     = 1'b0;
        end
        for (int a = 0; a < 256; a++) sbox_tab[a] = sboxCalc(8'(a));
        setKey(C1_KEY);

        step();
        step();
        checkOutput("rst_in_ready", in_ready[0], 0);
        checkOutput("rst_out_valid", out_valid[0], 0);
        checkOutput("rst_out_data", out_data[1], 0);
        checkOutput("rst_key_idx", key_idx[1], 0);
        rst_n = 1'b1;
        #1;
        checkOutput("rel_in_ready", in_ready[0], 1);

        // FIPS-197 C.1 at latency 1, then held under backpressure.
        runBlock(0, 1, C1_PT, C1_CT);
        for (int i = 0; i < 20; i++) begin
            step();
            checkOutput("bp_out_valid", out_valid[0], 1);
            checkOutput("bp_out_data", out_data[0], C1_CT);
            checkOutput("bp_in_ready", in_ready[0], 0);
        end
        finishBlock(0);

        // Same vector with a three-cycle datapath.
        runBlock(1, 3, C1_PT, C1_CT);
        finishBlock(1);

        // Flush beats a simultaneous in_valid in IDLE.
        in_valid[0] = 1'b1;
        flush[0]    = 1'b1;
        step();
        in_valid[0] = 1'b0;
        flush[0]    = 1'b0;
        checkOutput("flush_vs_accept", key_idx[0], 0);

        // Flush during round 5.
        applyStimulus(0, C1_PT);
        repeat (4) step();
        checkOutput("at_round5", key_idx[0], 5);
        flush[0] = 1'b1;
        step();
        flush[0] = 1'b0;
        checkOutput("flush_in_ready", in_ready[0], 1);
        checkOutput("flush_key_idx", key_idx[0], 0);
        seen = 1'b0;
        repeat (15) begin
            if (out_valid[0]) seen = 1'b1;
            step();
        end
        checkOutput("flush_no_out_valid", seen, 0);

        setKey('0);
        runBlock(0, 1, '0, ZERO_CT);
        flush[0]     = 1'b1;
        out_ready[0] = 1'b1;
        step();
        flush[0]     = 1'b0;
        out_ready[0] = 1'b0;
        checkOutput("flush_in_done_valid", out_valid[0], 0);
        checkOutput("flush_in_done_ready", in_ready[0], 1);

        // Reset for one cycle during round 7.
        applyStimulus(0, C1_PT);
        repeat (6) step();
        checkOutput("at_round7", key_idx[0], 7);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        checkOutput("midrst_out_valid", out_valid[0], 0);
        checkOutput("midrst_out_data", out_data[0], 0);
        checkOutput("midrst_out_data_l1", out_data[1], 0);
        checkOutput("midrst_in_ready", in_ready[0], 1);
        checkOutput("midrst_key_idx", key_idx[0], 0);

        runBlock(1, 3, '0, ZERO_CT);
        finishBlock(1);

`ifdef AES_ENCR_CTRL_PERF_EN
        checkOutput("perf_after_reset", blk_cnt[0], 0);
        for (int b = 0; b < 4; b++) begin
            runBlock(0, 1, '0, ZERO_CT);
            finishBlock(0);
        end
        applyStimulus(0, C1_PT);
        repeat (3) step();
        flush[0] = 1'b1;
        step();
        flush[0] = 1'b0;
        runBlock(0, 1, '0, ZERO_CT);
        flush[0]     = 1'b1;
        out_ready[0] = 1'b1;
        step();
        flush[0]     = 1'b0;
        out_ready[0] = 1'b0;
        checkOutput("perf_blk_cnt", blk_cnt[0], 4);
        checkOutput("perf_blk_cnt_l1", blk_cnt[1], 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
